bus2st: RTL and testbench
=========================

Name: bus2st

Overview:
- Feeds the turbo decoder input: unpacks wide parallel bus words into ST-bit Avalon-ST beats with sop/eop framing.
- One turbo packet is NUM_BUS_PER_TURBO_PKT bus words.
- Sits after the bus-side clock-domain-crossing FIFO and runs entirely in clk_st.
- A 2-word ping-pong buffer decouples bus bursts from decoder backpressure.

Parameters:
- ST_PER_BUS, 512: bus word width in bits.
- ST, 8: Avalon-ST beat width in bits.
- NUM_ST_PER_BUS, 64: beats per bus word (ST_PER_BUS/ST).
- NUM_BUS_PER_TURBO_PKT, 2: bus words per turbo packet.
- ST_PER_TURBO_PKT, 128: beats per packet (NUM_ST_PER_BUS*NUM_BUS_PER_TURBO_PKT).

Ports:
- clk_st  in  1  decoder clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- bus_data  in  ST_PER_BUS  bus word.
- bus_en  in  1  bus_data valid this cycle.
- bus_ready  out  1  block can accept a word this cycle.
- st_data  out  ST  beat data.
- st_valid  out  1  beat valid.
- st_sop  out  1  first beat of packet.
- st_eop  out  1  last beat of packet.
- st_ready  in  1  decoder accepts beat.
- pkt_done  out  1  one-cycle pulse after the eop beat is accepted.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - buffer count=0, wr_ptr=rd_ptr=0, beat_cnt=0, word_cnt=0, fsm=IDLE.
  - bus_ready=0, st_valid=0, st_sop=0, st_eop=0, pkt_done=0, st_data=0.
  - Reset mid-packet discards all buffered data and packet position; no eop is emitted.
- Buffer: 2 entries of ST_PER_BUS bits, 1-bit wr_ptr/rd_ptr, 2-bit count (0..2).
- Write:
  - Accepted when bus_en && bus_ready: entry[wr_ptr] <= bus_data, wr_ptr toggles.
  - bus_en while bus_ready=0 is ignored; data is dropped and state is unchanged.
- bus_ready is registered: each cycle bus_ready <= (count_next < 2), where count_next includes this cycle's write and word retire.
- Beat selection:
  - st_data = entry[rd_ptr][ST*beat_cnt +: ST], LSB slice first (beat 0 = bits ST-1:0).
  - This matches the MSB-shift-in packing on the output side.
  - st_data is combinational from registered state and holds while st_valid && !st_ready.
- st_valid = (fsm==SEND). A beat transfers when st_valid && st_ready.
- Counters on each transfer:
  - beat_cnt increments and wraps NUM_ST_PER_BUS-1 -> 0.
  - On wrap: word retires (rd_ptr toggles, count decrements); word_cnt increments and wraps NUM_BUS_PER_TURBO_PKT-1 -> 0.
- Framing:
  - st_sop = st_valid && beat_cnt==0 && word_cnt==0.
  - st_eop = st_valid && beat_cnt==NUM_ST_PER_BUS-1 && word_cnt==NUM_BUS_PER_TURBO_PKT-1.
- FSM:
  - IDLE -> SEND when count!=0 (first valid beat appears the cycle after the word is written; latency 1).
  - SEND -> IDLE when a word retires and count_next==0.
  - Otherwise SEND stays; back-to-back words and packets stream with no bubble.
- Simultaneous write and word retire: count unchanged; pointers both toggle.
- Full (count=2): bus_ready=0 from the following cycle.
  - The registered bus_ready already accounts for a same-cycle write, so there is no overflow under a compliant source.
- pkt_done: registered, high for exactly one cycle following the cycle in which the eop beat transferred.
- No sop/eop is asserted while st_valid=0. The packet position persists across IDLE gaps between words of one packet.

Optional Feature:
- Macro: BUS2ST_OVF_CNT_EN.
- Defined:
  - Adds output ovf_cnt [15:0], reset 0. It increments (saturating at 16'hFFFF) on every cycle with bus_en && !bus_ready.
  - Adds output ovf_flag, sticky, set on the first such event, cleared only by reset.
- Not defined: neither port exists. Dropped words are silently ignored; all other behaviour is identical.

Test Plan:
- Single packet, st_ready=1: write words W0, W1 (byte k of each = k) -> 128 consecutive beats; beat0 = W0[7:0] with sop; beat127 = W1[511:504] with eop; pkt_done one cycle after beat127.
- Backpressure: toggle st_ready every cycle over one packet -> each beat held stable while stalled; exactly 128 transfers; sop and eop each transfer once.
- Buffer full: write 3 words back-to-back with st_ready=0 -> bus_ready drops after 2nd write; 3rd write ignored; releasing st_ready drains W0 then W1 only.
- Streaming: 4 words continuously with st_ready=1 -> 256 beats with no gap; sop at beats 0 and 128; eop at beats 127 and 255.
- Reset mid-packet: assert rst_n=0 at beat 70 -> next cycle st_valid=0, bus_ready=0; next packet starts with sop on beat0 of the first new word.
- BUS2ST_OVF_CNT_EN defined: 5 cycles of bus_en while full -> ovf_cnt=5, ovf_flag=1; rst_n pulse clears both.

Source files
------------

// File: rtl/bus2st.sv
// Unpacks wide bus words into ST-bit Avalon-ST beats framed by sop/eop, through a 2-word ping-pong buffer.
// Optional build macro BUS2ST_OVF_CNT_EN adds ovf_cnt/ovf_flag to count writes dropped while the buffer is full.
module bus2st #(
  parameter int ST_PER_BUS            = 512,
  parameter int ST                    = 8,
  parameter int NUM_ST_PER_BUS        = ST_PER_BUS / ST,
  parameter int NUM_BUS_PER_TURBO_PKT = 2,
  parameter int ST_PER_TURBO_PKT      = NUM_ST_PER_BUS * NUM_BUS_PER_TURBO_PKT
) (
  input  logic                  clk_st,
  input  logic                  rst_n,
  input  logic [ST_PER_BUS-1:0] bus_data,
  input  logic                  bus_en,
  output logic                  bus_ready,
  output logic [ST-1:0]         st_data,
  output logic                  st_valid,
  output logic                  st_sop,
  output logic                  st_eop,
  input  logic                  st_ready,
  output logic                  pkt_done
`ifdef BUS2ST_OVF_CNT_EN
  ,
  output logic [15:0]           ovf_cnt,
  output logic                  ovf_flag
`endif
);

  localparam int BEAT_W = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
  localparam int WORD_W = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;
  localparam int PKT_W  = (ST_PER_TURBO_PKT > 1) ? $clog2(ST_PER_TURBO_PKT) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [NUM_ST_PER_BUS-1:0][ST-1:0] word_t;

  state_t              state_q, state_d;
  word_t               entry_q [2];
  word_t               entry_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic                bus_ready_q, bus_ready_d;
  logic                pkt_done_q, pkt_done_d;

  logic                wr_en;
  logic                xfer;
  logic                beat_last;
  logic                word_last;
  logic                retire;
  logic [PKT_W-1:0]    pkt_pos;

  assign st_valid  = (state_q == SEND);
  assign wr_en     = bus_en && bus_ready_q;
  assign xfer      = st_valid && st_ready;
  assign beat_last = (beat_cnt_q == BEAT_W'(NUM_ST_PER_BUS - 1));
  assign word_last = (word_cnt_q == WORD_W'(NUM_BUS_PER_TURBO_PKT - 1));
  assign retire    = xfer && beat_last;

  // Packet-relative beat index drives the framing flags.
  assign pkt_pos   = PKT_W'(word_cnt_q) * PKT_W'(NUM_ST_PER_BUS) + PKT_W'(beat_cnt_q);
  assign st_sop    = st_valid && (pkt_pos == '0);
  assign st_eop    = st_valid && (pkt_pos == PKT_W'(ST_PER_TURBO_PKT - 1));
  assign st_data   = st_valid ? entry_q[rd_ptr_q][beat_cnt_q] : '0;
  assign bus_ready = bus_ready_q;
  assign pkt_done  = pkt_done_q;

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      entry_d[wr_ptr_q] = bus_data;
      wr_ptr_d          = ~wr_ptr_q;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    if (xfer) begin
      if (beat_last) begin
        beat_cnt_d = '0;
        rd_ptr_d   = ~rd_ptr_q;
        word_cnt_d = word_last ? '0 : word_cnt_q + WORD_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  // Ready looks ahead at this cycle's write and retire so a compliant source never overflows.
  always_comb begin
    count_d     = count_q + 2'(wr_en) - 2'(retire);
    bus_ready_d = (count_d < 2'd2);
    pkt_done_d  = xfer && st_eop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count_q != 2'd0) state_d = SEND;
      SEND: if (retire && (count_d == 2'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_st) begin
    entry_q <= entry_d;
  end

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
      bus_ready_q <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      bus_ready_q <= bus_ready_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

`ifdef BUS2ST_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        ovf_flag_q, ovf_flag_d;

  always_comb begin
    ovf_cnt_d  = ovf_cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (bus_en && !bus_ready_q) begin
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
      ovf_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      ovf_cnt_q  <= 16'd0;
      ovf_flag_q <= 1'b0;
    end else begin
      ovf_cnt_q  <= ovf_cnt_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  assign ovf_cnt  = ovf_cnt_q;
  assign ovf_flag = ovf_flag_q;
`endif

endmodule

// File: tb/tb_bus2st.sv
// Scoreboard bench for bus2st: expected beats are queued when a word is accepted and popped on each beat transfer.
// Define BUS2ST_OVF_CNT_EN for both files to also exercise the overflow counter.
module tb_bus2st;

   localparam int BUSW = 512;
   localparam int STW  = 8;
   localparam int NBEAT = BUSW / STW;

   typedef struct packed {
      logic [STW-1:0] data;
      logic           sop;
      logic           eop;
   } beat_t;

   logic            clk_st = 1'b0;
   logic            rst_n;
   logic [BUSW-1:0] bus_data;
   logic            bus_en;
   logic            bus_ready;
   logic [STW-1:0]  st_data;
   logic            st_valid;
   logic            st_sop;
   logic            st_eop;
   logic            st_ready;
   logic            pkt_done;
`ifdef BUS2ST_OVF_CNT_EN
   logic [15:0]     ovf_cnt;
   logic            ovf_flag;
`endif

   int checkCount = 0;
   int passCount  = 0;

   beat_t expQ[$];
   int    tbWordCnt = 0;
   int    readyMode = 0;

   int    cycleCnt = 0;
   int    xferCount = 0;
   int    sopCount = 0;
   int    eopCount = 0;
   int    gapCount = 0;
   int    pktDoneCount = 0;
   int    lastXferCyc = -10;
   logic  expPktDone = 1'b0;
   logic  stalledPrev = 1'b0;
   logic [STW-1:0] heldData = '0;

   bus2st dut (
      .clk_st    (clk_st),
      .rst_n     (rst_n),
      .bus_data  (bus_data),
      .bus_en    (bus_en),
      .bus_ready (bus_ready),
      .st_data   (st_data),
      .st_valid  (st_valid),
      .st_sop    (st_sop),
      .st_eop    (st_eop),
      .st_ready  (st_ready),
      .pkt_done  (pkt_done)
`ifdef BUS2ST_OVF_CNT_EN
      ,
      .ovf_cnt   (ovf_cnt),
      .ovf_flag  (ovf_flag)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk_st = ~clk_st;

   // Single driver for st_ready: held low, held high, or toggled every cycle.
   always @(posedge clk_st) begin
      #2;
      case (readyMode)
         0: st_ready = 1'b0;
         1: st_ready = 1'b1;
         default: st_ready = ~st_ready;
      endcase
   end

   // Hard stop in case something in the bench itself stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts a comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // Queues the 64 beats a word is expected to produce, with framing from the packet model.
   task automatic pushWord(input logic [BUSW-1:0] word);
      beat_t b;
      for (int k = 0; k < NBEAT; k++) begin
         b.data = word[STW*k +: STW];
         b.sop  = (k == 0) && (tbWordCnt == 0);
         b.eop  = (k == NBEAT-1) && (tbWordCnt == 1);
         expQ.push_back(b);
      end
      tbWordCnt = (tbWordCnt + 1) % 2;
   endtask

   // Offers a word with bus_en until the block takes it; entered and left at posedge+1.
   task automatic applyStimulus(input logic [BUSW-1:0] word);
      logic accepted;
      accepted = 1'b0;
      bus_en   = 1'b1;
      bus_data = word;
      for (int t = 0; t < 2000 && !accepted; t++) begin
         @(negedge clk_st);
         accepted = bus_ready;
         @(posedge clk_st);
         #1;
      end
      bus_en = 1'b0;
      if (accepted) pushWord(word);
      else checkOutput("write_timeout", {63'd0, accepted}, 64'd1);
   endtask

   task automatic waitDrain(input int budget);
      int t;
      t = 0;
      while (expQ.size() != 0 && t < budget) begin
         @(posedge clk_st);
         #1;
         t++;
      end
      checkOutput("drain_left", 64'(expQ.size()), 64'd0);
      repeat (4) begin
         @(posedge clk_st);
         #1;
      end
   endtask

   function automatic logic [BUSW-1:0] rampWord();
      logic [BUSW-1:0] w;
      for (int k = 0; k < NBEAT; k++) w[STW*k +: STW] = STW'(k);
      return w;
   endfunction

   function automatic logic [BUSW-1:0] randWord();
      logic [BUSW-1:0] w;
      for (int k = 0; k < BUSW/32; k++) w[32*k +: 32] = $urandom;
      return w;
   endfunction

   // Beat monitor: pops the scoreboard on each transfer and checks stall hold, framing and pkt_done timing.
   always @(negedge clk_st) begin
      beat_t e;
      cycleCnt++;
      if (!rst_n) begin
         expQ.delete();
         expPktDone  = 1'b0;
         stalledPrev = 1'b0;
      end else begin
         if (expPktDone || pkt_done) checkOutput("pkt_done", {63'd0, pkt_done}, {63'd0, expPktDone});
         if (pkt_done) pktDoneCount++;
         expPktDone = 1'b0;
         if (stalledPrev) begin
            checkOutput("hold_valid", {63'd0, st_valid}, 64'd1);
            checkOutput("hold_data", {56'd0, st_data}, {56'd0, heldData});
         end
         if (!st_valid && (st_sop || st_eop)) checkOutput("idle_frame", {62'd0, st_sop, st_eop}, 64'd0);
         if (st_valid && st_ready) begin
            xferCount++;
            if (st_sop) sopCount++;
            if (st_eop) eopCount++;
            if (lastXferCyc != cycleCnt - 1) gapCount++;
            lastXferCyc = cycleCnt;
            if (expQ.size() == 0) begin
               checkOutput("extra_beat", {63'd0, st_valid}, 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("beat_data", {56'd0, st_data}, {56'd0, e.data});
               checkOutput("beat_sop", {63'd0, st_sop}, {63'd0, e.sop});
               checkOutput("beat_eop", {63'd0, st_eop}, {63'd0, e.eop});
               expPktDone = e.eop;
            end
         end
         stalledPrev = st_valid && !st_ready;
         heldData    = st_data;
      end
   end

   initial begin
      int baseX, baseSop, baseEop, baseGap, basePd;
      rst_n     = 1'b0;
      bus_en    = 1'b0;
      bus_data  = '0;
      readyMode = 0;

      // Reset state.
      repeat (3) @(posedge clk_st);
      @(negedge clk_st);
      checkOutput("rst_bus_ready", {63'd0, bus_ready}, 64'd0);
      checkOutput("rst_st_valid", {63'd0, st_valid}, 64'd0);
      checkOutput("rst_sop_eop", {62'd0, st_sop, st_eop}, 64'd0);
      checkOutput("rst_pkt_done", {63'd0, pkt_done}, 64'd0);
      checkOutput("rst_st_data", {56'd0, st_data}, 64'd0);
`ifdef BUS2ST_OVF_CNT_EN
      checkOutput("rst_ovf_cnt", {48'd0, ovf_cnt}, 64'd0);
      checkOutput("rst_ovf_flag", {63'd0, ovf_flag}, 64'd0);
`endif
      @(posedge clk_st);
      #1;
      rst_n = 1'b1;
      @(negedge clk_st);
      @(negedge clk_st);
      checkOutput("ready_after_rst", {63'd0, bus_ready}, 64'd1);
      @(posedge clk_st);
      #1;

      // Single packet, decoder always ready.
      $display("[TB] single packet");
      readyMode = 1;
      baseX = xferCount; baseSop = sopCount; baseEop = eopCount; basePd = pktDoneCount;
      applyStimulus(rampWord());
      applyStimulus(rampWord());
      waitDrain(1000);
      checkOutput("single_xfers", 64'(xferCount - baseX), 64'd128);
      checkOutput("single_sop", 64'(sopCount - baseSop), 64'd1);
      checkOutput("single_eop", 64'(eopCount - baseEop), 64'd1);
      checkOutput("single_pkt_done", 64'(pktDoneCount - basePd), 64'd1);

      // Backpressure toggling every cycle.
      $display("[TB] backpressure");
      readyMode = 2;
      baseX = xferCount; baseSop = sopCount; baseEop = eopCount;
      applyStimulus(randWord());
      applyStimulus(randWord());
      waitDrain(2000);
      checkOutput("bp_xfers", 64'(xferCount - baseX), 64'd128);
      checkOutput("bp_sop", 64'(sopCount - baseSop), 64'd1);
      checkOutput("bp_eop", 64'(eopCount - baseEop), 64'd1);

      // Buffer full: third back-to-back write must be dropped.
      $display("[TB] buffer full");
      readyMode = 0;
      @(posedge clk_st);
      #1;
      baseX = xferCount;
      bus_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [BUSW-1:0] w;
         w = randWord();
         bus_data = w;
         @(negedge clk_st);
         checkOutput($sformatf("full_ready%0d", i), {63'd0, bus_ready}, (i < 2) ? 64'd1 : 64'd0);
         if (i < 2) pushWord(w);
         @(posedge clk_st);
         #1;
      end
      bus_en = 1'b0;
      @(negedge clk_st);
      checkOutput("full_ready_hold", {63'd0, bus_ready}, 64'd0);
      @(posedge clk_st);
      #1;
      readyMode = 1;
      waitDrain(1000);
      repeat (20) @(posedge clk_st);
      #1;
      checkOutput("full_xfers", 64'(xferCount - baseX), 64'd128);

      // Streaming four words with no bubble.
      $display("[TB] streaming");
      baseX = xferCount; baseSop = sopCount; baseEop = eopCount; baseGap = gapCount;
      for (int i = 0; i < 4; i++) applyStimulus(randWord());
      waitDrain(2000);
      checkOutput("stream_xfers", 64'(xferCount - baseX), 64'd256);
      checkOutput("stream_sop", 64'(sopCount - baseSop), 64'd2);
      checkOutput("stream_eop", 64'(eopCount - baseEop), 64'd2);
      checkOutput("stream_gaps", 64'(gapCount - baseGap), 64'd1);

      // Reset in the middle of a packet.
      $display("[TB] reset mid-packet");
      baseX = xferCount;
      applyStimulus(randWord());
      applyStimulus(randWord());
      for (int t = 0; t < 1000 && (xferCount - baseX) < 70; t++) begin
         @(posedge clk_st);
         #1;
      end
      checkOutput("mid_reached", {63'd0, (xferCount - baseX) >= 70}, 64'd1);
      rst_n = 1'b0;
      @(posedge clk_st);
      #1;
      @(negedge clk_st);
      checkOutput("mid_rst_valid", {63'd0, st_valid}, 64'd0);
      checkOutput("mid_rst_ready", {63'd0, bus_ready}, 64'd0);
      @(posedge clk_st);
      #1;
      rst_n     = 1'b1;
      tbWordCnt = 0;
      baseSop = sopCount; baseEop = eopCount;
      applyStimulus(randWord());
      applyStimulus(randWord());
      waitDrain(1000);
      checkOutput("post_rst_sop", 64'(sopCount - baseSop), 64'd1);
      checkOutput("post_rst_eop", 64'(eopCount - baseEop), 64'd1);

`ifdef BUS2ST_OVF_CNT_EN
      // Overflow counting: two writes fill the buffer, five more are dropped.
      $display("[TB] overflow counter");
      checkOutput("ovf_start", {48'd0, ovf_cnt}, 64'd0);
      readyMode = 0;
      @(posedge clk_st);
      #1;
      bus_en = 1'b1;
      repeat (7) begin
         bus_data = randWord();
         @(posedge clk_st);
         #1;
      end
      bus_en = 1'b0;
      @(negedge clk_st);
      checkOutput("ovf_cnt", {48'd0, ovf_cnt}, 64'd5);
      checkOutput("ovf_flag", {63'd0, ovf_flag}, 64'd1);
      @(posedge clk_st);
      #1;
      rst_n = 1'b0;
      @(posedge clk_st);
      #1;
      rst_n = 1'b1;
      @(negedge clk_st);
      checkOutput("ovf_cnt_clr", {48'd0, ovf_cnt}, 64'd0);
      checkOutput("ovf_flag_clr", {63'd0, ovf_flag}, 64'd0);
`endif

      repeat (4) @(posedge clk_st);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
